// File: rtl/sap1_controller.sv
// SAP-1 Moore control sequencer: one-hot T1..T6 ring plus opcode decode drives all datapath strobes.
// Outputs depend only on state (and clr); HLT freezes the ring at T5 until clr.
module sap1_controller #(
   parameter int opw = 4
) (
   input  logic           clk,
   input  logic           clr,
   input  logic [opw-1:0] opcode,
   output logic [5:0]     t,
   output logic           Cp,
   output logic           Ep,
   output logic           Lm,
   output logic           CE,
   output logic           Li,
   output logic           Ei,
   output logic           La,
   output logic           Ea,
   output logic           Su,
   output logic           Eu,
   output logic           Lb,
   output logic           Lo,
   output logic           hlt
);

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   localparam logic [opw-1:0] OP_LDA = opw'(4'b0000);
   localparam logic [opw-1:0] OP_ADD = opw'(4'b0001);
   localparam logic [opw-1:0] OP_SUB = opw'(4'b0010);
   localparam logic [opw-1:0] OP_OUT = opw'(4'b1110);
   localparam logic [opw-1:0] OP_HLT = opw'(4'b1111);

   logic [5:0] r_t;
   logic       r_halted;
   logic [5:0] w_t_next;
   logic       w_halted_next;
   logic       w_onehot;

   assign w_onehot = (r_t != 6'd0) && ((r_t & (r_t - 6'd1)) == 6'd0);
   assign t        = r_t;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_t      <= T1;
         r_halted <= 1'b0;
      end else begin
         r_t      <= w_t_next;
         r_halted <= w_halted_next;
      end
   end

   // A corrupted ring always recovers to T1; a halted ring holds at T5.
   always_comb begin
      w_t_next      = T1;
      w_halted_next = r_halted;
      if (w_onehot) begin
         if (r_halted) begin
            w_t_next = r_t;
         end else begin
            w_t_next = {r_t[4:0], r_t[5]};
            if ((r_t == T4) && (opcode == OP_HLT)) begin
               w_halted_next = 1'b1;
            end
         end
      end
   end

   always_comb begin
      Cp  = 1'b0;
      Ep  = 1'b0;
      Lm  = 1'b0;
      CE  = 1'b0;
      Li  = 1'b0;
      Ei  = 1'b0;
      La  = 1'b0;
      Ea  = 1'b0;
      Su  = 1'b0;
      Eu  = 1'b0;
      Lb  = 1'b0;
      Lo  = 1'b0;
      hlt = r_halted & ~clr;
      if (!clr && !r_halted) begin
         // Exact-match decode keeps bus drivers exclusive even for a non-one-hot ring.
         case (r_t)
            T1: begin Ep = 1'b1; Lm = 1'b1; end
            T2: Cp = 1'b1;
            T3: begin CE = 1'b1; Li = 1'b1; end
            T4: begin
               if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                  Ei = 1'b1;
                  Lm = 1'b1;
               end else if (opcode == OP_OUT) begin
                  Ea = 1'b1;
                  Lo = 1'b1;
               end
            end
            T5: begin
               if (opcode == OP_LDA) begin
                  CE = 1'b1;
                  La = 1'b1;
               end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                  CE = 1'b1;
                  Lb = 1'b1;
               end
            end
            T6: begin
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  Eu = 1'b1;
                  La = 1'b1;
                  Su = (opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for sap1_controller: fetch/execute strobes, HLT freeze, clr abort, bus exclusivity.
module tb_sap1_controller;

   localparam logic [11:0] M_CP = 12'h800;
   localparam logic [11:0] M_EP = 12'h400;
   localparam logic [11:0] M_LM = 12'h200;
   localparam logic [11:0] M_CE = 12'h100;
   localparam logic [11:0] M_LI = 12'h080;
   localparam logic [11:0] M_EI = 12'h040;
   localparam logic [11:0] M_LA = 12'h020;
   localparam logic [11:0] M_EA = 12'h010;
   localparam logic [11:0] M_SU = 12'h008;
   localparam logic [11:0] M_EU = 12'h004;
   localparam logic [11:0] M_LB = 12'h002;
   localparam logic [11:0] M_LO = 12'h001;
   localparam logic [11:0] NONE = 12'h000;

   logic       clk = 1'b0;
   logic       clr;
   logic [3:0] opcode;
   logic [5:0] t;
   logic       Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, hlt;
   logic [11:0] ctl;

   int tests = 0;
   int fails = 0;

   sap1_controller #(.opw(4)) dut (
      .clk(clk), .clr(clr), .opcode(opcode), .t(t),
      .Cp(Cp), .Ep(Ep), .Lm(Lm), .CE(CE), .Li(Li), .Ei(Ei), .La(La),
      .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo), .hlt(hlt)
   );

   assign ctl = {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo};

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
      end
   endtask

   // Checks T1..T4 of one instruction and leaves the bench in the T5 cycle.
   task automatic run_to_t5(input string tag, input logic [3:0] op, input logic [11:0] e4);
      logic [11:0] e [4];
      logic [5:0]  et;
      e = '{M_EP | M_LM, M_CP, M_CE | M_LI, e4};
      opcode = op;
      #1;
      for (int k = 0; k < 4; k++) begin
         et = 6'b000001 << k;
         chk($sformatf("%s_t%0d_state", tag, k + 1), {6'b0, t}, {6'b0, et});
         chk($sformatf("%s_t%0d_ctl", tag, k + 1), ctl, e[k]);
         chk($sformatf("%s_t%0d_hlt", tag, k + 1), {11'b0, hlt}, 12'h000);
         step();
      end
   endtask

   task automatic run_instr(input string tag, input logic [3:0] op,
                            input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6);
      run_to_t5(tag, op, e4);
      chk({tag, "_t5_state"}, {6'b0, t}, 12'h010);
      chk({tag, "_t5_ctl"}, ctl, e5);
      step();
      chk({tag, "_t6_state"}, {6'b0, t}, 12'h020);
      chk({tag, "_t6_ctl"}, ctl, e6);
      chk({tag, "_t6_hlt"}, {11'b0, hlt}, 12'h000);
      step();
   endtask

   initial begin
      int viol;
      clr    = 1'b1;
      opcode = 4'b0000;

      // Reset held for two edges
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_state", {6'b0, t}, 12'h001);
         chk("rst_ctl", ctl, NONE);
         chk("rst_hlt", {11'b0, hlt}, 12'h000);
      end
      clr = 1'b0;

      // Two LDA instructions: 12 cycles of one-hot ring
      run_instr("lda0", 4'b0000, M_EI | M_LM, M_CE | M_LA, NONE);
      run_instr("lda1", 4'b0000, M_EI | M_LM, M_CE | M_LA, NONE);
      run_instr("add", 4'b0001, M_EI | M_LM, M_CE | M_LB, M_EU | M_LA);
      run_instr("sub", 4'b0010, M_EI | M_LM, M_CE | M_LB, M_EU | M_LA | M_SU);
      run_instr("out", 4'b1110, M_EA | M_LO, NONE, NONE);
      run_instr("nop", 4'b0101, NONE, NONE, NONE);

      // HLT: freeze at T5 regardless of opcode
      run_to_t5("hlt", 4'b1111, NONE);
      for (int i = 0; i < 20; i++) begin
         chk("halt_state", {6'b0, t}, 12'h010);
         chk("halt_ctl", ctl, NONE);
         chk("halt_hlt", {11'b0, hlt}, 12'h001);
         opcode = 4'($urandom_range(0, 15));
         step();
      end
      clr = 1'b1;
      #1;
      chk("halt_clr_hlt", {11'b0, hlt}, 12'h000);
      chk("halt_clr_ctl", ctl, NONE);
      step();
      chk("halt_clr_state", {6'b0, t}, 12'h001);
      clr = 1'b0;
      run_instr("post_halt", 4'b0000, M_EI | M_LM, M_CE | M_LA, NONE);

      // Abort SUB in T5
      run_to_t5("abort", 4'b0010, M_EI | M_LM);
      chk("abort_t5_ctl", ctl, M_CE | M_LB);
      clr = 1'b1;
      #1;
      chk("abort_clr_ctl", ctl, NONE);
      step();
      chk("abort_state", {6'b0, t}, 12'h001);
      chk("abort_ctl", ctl, NONE);
      clr = 1'b0;
      run_instr("after_abort", 4'b0010, M_EI | M_LM, M_CE | M_LB, M_EU | M_LA | M_SU);

      // Random stream of non-halting instructions
      viol = 0;
      for (int i = 0; i < 200; i++) begin
         opcode = 4'($urandom_range(0, 14));
         for (int k = 0; k < 6; k++) begin
            if ($countones({Ep, CE, Ei, Ea, Eu}) > 1) viol++;
            if (!$onehot(t)) viol++;
            if (Su && !Eu) viol++;
            step();
         end
      end
      chk("rand_violations", 12'(viol), 12'h000);
      chk("rand_end_state", {6'b0, t}, 12'h001);

      // Illegal ring value must steer back to T1
      @(negedge clk);
      force dut.r_t = 6'b000011;
      #1;
      chk("illegal_next", {6'b0, dut.w_t_next}, 12'h001);
      chk("illegal_ctl", ctl, NONE);
      release dut.r_t;
      clr = 1'b1;
      step();
      clr = 1'b0;
      #1;
      chk("illegal_recover_state", {6'b0, t}, 12'h001);
      chk("illegal_recover_ctl", ctl, M_EP | M_LM);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
